// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM.
// MC_ILLEGAL_TRAP_EN adds the TRAP state for unknown opcodes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    R_EXEC   = 4'd7,
    R_WB     = 4'd8,
    I_EXEC   = 4'd9,
    I_WB     = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12
`ifdef MC_ILLEGAL_TRAP_EN
    , TRAP   = 4'd13
`endif
  } mc_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_known(input logic [5:0] op);
    logic known_s;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_SLTI, OP_BEQ, OP_J: known_s = 1'b1;
      default:                                                known_s = 1'b0;
    endcase
    return known_s;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// R-type funct field to 3-bit ALU operation; unknown functs fall back to ADD.
module alu_op_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op
);

  // funct lookup
  always_comb begin
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM with memory ready handshake and retire counter.
// Optional MC_ILLEGAL_TRAP_EN parks unknown opcodes in TRAP until reset.
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic        pc_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        retire,
  output logic [31:0] instr_count,
  output logic        illegal
);

  mc_state_e   state_r;
  mc_state_e   next_state_s;
  logic [2:0]  funct_op_s;
  logic [31:0] count_r;

  alu_op_decode u_alu_op_decode (
    .funct  (funct),
    .alu_op (funct_op_s)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= next_state_s;
  end

  // next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:     next_state_s = FETCH;
      FETCH:    next_state_s = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:        next_state_s = R_EXEC;
          OP_LW, OP_SW:    next_state_s = MEM_ADDR;
          OP_ADDI, OP_SLTI: next_state_s = I_EXEC;
          OP_BEQ:          next_state_s = BRANCH;
          OP_J:            next_state_s = JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
          default:         next_state_s = TRAP;
`else
          default:         next_state_s = FETCH;
`endif
        endcase
      end
      MEM_ADDR: next_state_s = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   next_state_s = mem_ready ? MEM_WB : MEM_RD;
      MEM_WR:   next_state_s = mem_ready ? FETCH : MEM_WR;
      R_EXEC:   next_state_s = R_WB;
      I_EXEC:   next_state_s = I_WB;
      MEM_WB, R_WB, I_WB, BRANCH, JUMP: next_state_s = FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      TRAP:     next_state_s = TRAP;
`endif
      default:  next_state_s = IDLE;
    endcase
  end

  // output decode: Moore except fetch/branch enables and the sw retire
  always_comb begin
    alu_op     = 3'b000;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state_r)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        pc_src    = PCSRC_ALU;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_op    = ALU_ADD;
`ifndef MC_ILLEGAL_TRAP_EN
        retire    = ~op_known(opcode);
`endif
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire    = mem_ready;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_B;
        alu_op    = funct_op_s;
      end
      R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      I_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_B;
        alu_op    = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_write  = zero;
        retire    = 1'b1;
      end
      JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        retire   = 1'b1;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      TRAP:    illegal = 1'b1;
`endif
      default: illegal = 1'b0;
    endcase
  end

  // retired-instruction counter, wraps naturally at 32 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count_r <= 32'd0;
    else if (retire) count_r <= count_r + 32'd1;
    else             count_r <= count_r;
  end

  assign instr_count = count_r;

endmodule
